term_ctrl: RTL

TERM_CTRL -- requirements
Module: term_ctrl

---
 rtl/term_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/term_ctrl.sv
// term_ctrl: character terminal controller driving a scrolling VRAM through a valid/ready write port
module term_ctrl #(
  parameter int COLS = 100,
  parameter int ROWS = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  output logic       write_valid,
  input  logic       write_ready,
  output logic [4:0] write_row,
  output logic [6:0] write_col,
  output logic [7:0] write_char,
  output logic [4:0] top_row,
  output logic [4:0] cursor_row,
  output logic [6:0] cursor_col
);
  typedef enum logic [1:0] {CLEAR_ALL, IDLE, WRITE, CLEAR_ROW} state_t;
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  state_t state;
  logic [5:0] row_sum;
  logic [4:0] phys_row, top_next;
  logic xfer, accept, at_last_row, printable;
  // Cursor-to-physical row mapping uses a 6-bit sum so top_row+cursor_row never wraps early
  always_comb begin
    row_sum     = {1'b0, top_row} + {1'b0, cursor_row};
    phys_row    = row_sum >= 6'(ROWS) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
    top_next    = top_row == LAST_ROW ? 5'd0 : top_row + 5'd1;
    xfer        = write_valid && write_ready;
    accept      = in_valid && in_ready;
    at_last_row = cursor_row == LAST_ROW;
    printable   = in_char >= 8'h20 && in_char <= 8'h7e;
  end
  // Control FSM; write_row/write_col double as the clear pointer in CLEAR_ALL and CLEAR_ROW
  always_ff @(posedge clk) begin
    if (!reset_low) begin
      state       <= CLEAR_ALL;
      in_ready    <= 1'b0;
      write_valid <= 1'b0;
      write_row   <= 5'd0;
      write_col   <= 7'd0;
      write_char  <= BLANK;
      top_row     <= 5'd0;
      cursor_row  <= 5'd0;
      cursor_col  <= 7'd0;
    end else begin
      case (state)
        CLEAR_ALL: begin
          if (!write_valid) write_valid <= 1'b1;
          else if (xfer) begin
            if (write_col == LAST_COL) begin
              write_col <= 7'd0;
              if (write_row == LAST_ROW) begin
                write_row   <= 5'd0;
                write_valid <= 1'b0;
                in_ready    <= 1'b1;
                state       <= IDLE;
              end else write_row <= write_row + 5'd1;
            end else write_col <= write_col + 7'd1;
          end
        end
        IDLE: begin
          if (accept) begin
            if (printable) begin
              in_ready    <= 1'b0;
              write_valid <= 1'b1;
              write_row   <= phys_row;
              write_col   <= cursor_col;
              write_char  <= in_char;
              state       <= WRITE;
            end else if (in_char == 8'h0a) begin
              if (!at_last_row) cursor_row <= cursor_row + 5'd1;
              else begin
                top_row     <= top_next;
                in_ready    <= 1'b0;
                write_valid <= 1'b1;
                write_row   <= top_row;
                write_col   <= 7'd0;
                write_char  <= BLANK;
                state       <= CLEAR_ROW;
              end
            end else if (in_char == 8'h0d) cursor_col <= 7'd0;
            else if (in_char == 8'h08 && cursor_col != 7'd0) cursor_col <= cursor_col - 7'd1;
          end
        end
        WRITE: begin
          if (xfer) begin
            if (cursor_col != LAST_COL) begin
              cursor_col  <= cursor_col + 7'd1;
              write_valid <= 1'b0;
              in_ready    <= 1'b1;
              state       <= IDLE;
            end else begin
              cursor_col <= 7'd0;
              if (!at_last_row) begin
                cursor_row  <= cursor_row + 5'd1;
                write_valid <= 1'b0;
                in_ready    <= 1'b1;
                state       <= IDLE;
              end else begin
                top_row    <= top_next;
                write_row  <= top_row;
                write_col  <= 7'd0;
                write_char <= BLANK;
                state      <= CLEAR_ROW;
              end
            end
          end
        end
        CLEAR_ROW: begin
          if (xfer) begin
            if (write_col == LAST_COL) begin
              write_valid <= 1'b0;
              in_ready    <= 1'b1;
              state       <= IDLE;
            end else write_col <= write_col + 7'd1;
          end
        end
        default: state <= CLEAR_ALL;
      endcase
    end
  end
endmodule
